// File: rtl/key_debounce_wb.sv
// Wishbone key/button input port: per-bit 2-FF sync, stable-time debounce,
// level register plus sticky press/release flags with a maskable interrupt.
module key_debounce_wb #(
    parameter int PORT_WIDTH      = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int Dw              = 32,
    parameter int Aw              = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PORT_WIDTH-1:0] key_port_i,
    input  logic [Dw-1:0]         sa_dat_i,
    input  logic [Dw/8-1:0]       sa_sel_i,
    input  logic [Aw-1:0]         sa_addr_i,
    input  logic                  sa_stb_i,
    input  logic                  sa_cyc_i,
    input  logic                  sa_we_i,
    output logic [Dw-1:0]         sa_dat_o,
    output logic                  sa_ack_o,
    output logic                  sa_err_o,
    output logic                  sa_rty_o,
    output logic                  irq
);

    localparam int              CW         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            PIN_IDLE   = (ACTIVE_LOW != 0);
    localparam logic [Aw-1:0]   ADDR_STATE = Aw'(0);
    localparam logic [Aw-1:0]   ADDR_PRESS = Aw'(1);
    localparam logic [Aw-1:0]   ADDR_REL   = Aw'(2);
    localparam logic [Aw-1:0]   ADDR_IE    = Aw'(3);

    logic [PORT_WIDTH-1:0] sync_p0, sync_p1;
    logic [PORT_WIDTH-1:0] key_s;
    logic [PORT_WIDTH-1:0] db;
    logic [CW-1:0]         cnt [PORT_WIDTH];
    logic [PORT_WIDTH-1:0] db_done, press_pls, rel_pls;
    logic [PORT_WIDTH-1:0] press_flg, rel_flg, ie;
    logic [PORT_WIDTH-1:0] press_clr, rel_clr;
    logic                  bus_req, wr_en;
    logic [Dw-1:0]         rd_data;
    logic                  unused_ok;

    assign unused_ok = ^{sa_sel_i, sa_dat_i};

    // Stage p0/p1: synchronizer, idles at the released pin level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= {PORT_WIDTH{PIN_IDLE}};
            sync_p1 <= {PORT_WIDTH{PIN_IDLE}};
        end else begin
            sync_p0 <= key_port_i;
            sync_p1 <= sync_p0;
        end
    end

    assign key_s = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

    // Debounce: a change is accepted once it has held for DEBOUNCE_CYCLES edges
    always_comb begin
        db_done = '0;
        for (int i = 0; i < PORT_WIDTH; i++)
            db_done[i] = (key_s[i] != db[i]) && (cnt[i] == CNT_MAX);
    end

    assign press_pls = db_done & key_s;
    assign rel_pls   = db_done & ~key_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db <= '0;
            for (int i = 0; i < PORT_WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < PORT_WIDTH; i++) begin
                if (key_s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (db_done[i]) begin
                    cnt[i] <= '0;
                    db[i]  <= key_s[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Bus: one registered ack per request, ack itself blocks the next cycle
    assign bus_req   = sa_stb_i & sa_cyc_i & ~sa_ack_o;
    assign wr_en     = bus_req & sa_we_i;
    assign press_clr = (wr_en && sa_addr_i == ADDR_PRESS) ? sa_dat_i[PORT_WIDTH-1:0] : '0;
    assign rel_clr   = (wr_en && sa_addr_i == ADDR_REL)   ? sa_dat_i[PORT_WIDTH-1:0] : '0;

    always_comb begin
        rd_data = '0;
        case (sa_addr_i)
            ADDR_STATE: rd_data[PORT_WIDTH-1:0] = db;
            ADDR_PRESS: rd_data[PORT_WIDTH-1:0] = press_flg;
            ADDR_REL:   rd_data[PORT_WIDTH-1:0] = rel_flg;
            ADDR_IE:    rd_data[PORT_WIDTH-1:0] = ie;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa_ack_o  <= 1'b0;
            sa_dat_o  <= '0;
            press_flg <= '0;
            rel_flg   <= '0;
            ie        <= '0;
        end else begin
            sa_ack_o  <= bus_req;
            sa_dat_o  <= bus_req ? rd_data : '0;
            // set after clear so a coincident hardware event is never lost
            press_flg <= (press_flg & ~press_clr) | press_pls;
            rel_flg   <= (rel_flg & ~rel_clr) | rel_pls;
            if (wr_en && sa_addr_i == ADDR_IE)
                ie <= sa_dat_i[PORT_WIDTH-1:0];
        end
    end

    assign irq      = |((press_flg | rel_flg) & ie);
    assign sa_err_o = 1'b0;
    assign sa_rty_o = 1'b0;

endmodule

// File: tb/tb_key_debounce_wb.sv
// Directed bench for key_debounce_wb with DEBOUNCE_CYCLES=4, 4 active-low keys.
module tb_key_debounce_wb;

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_PRESS = 2'd1;
    localparam logic [1:0] A_REL   = 2'd2;
    localparam logic [1:0] A_IE    = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  keys;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [1:0]  addr;
    logic        stb, cyc, we;
    logic [31:0] rdat;
    logic        ack, err, rty, irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] d;
    logic        irq_w;

    always #5 clk = ~clk;

    key_debounce_wb #(
        .PORT_WIDTH(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .Dw(32), .Aw(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_port_i(keys),
        .sa_dat_i(wdat), .sa_sel_i(sel), .sa_addr_i(addr),
        .sa_stb_i(stb), .sa_cyc_i(cyc), .sa_we_i(we),
        .sa_dat_o(rdat), .sa_ack_o(ack), .sa_err_o(err), .sa_rty_o(rty),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered on a negedge; the request is sampled at the next posedge.
    task automatic bus_rd(input logic [1:0] a, output logic [31:0] data);
        addr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        @(negedge clk);
        check("rd_ack", 32'(ack), 32'd1);
        data = rdat;
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check("rd_ack_drop", 32'(ack), 32'd0);
        check("rd_dat_idle", rdat, 32'd0);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] data, output logic irq_at_ack);
        addr = a; wdat = data; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(negedge clk);
        check("wr_ack", 32'(ack), 32'd1);
        irq_at_ack = irq;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check("wr_ack_drop", 32'(ack), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; keys = 4'hF; wdat = '0; sel = 4'hF; addr = '0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dat", rdat, 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        bus_rd(A_STATE, d); check("idle_state", d, 32'h0);
        bus_rd(A_PRESS, d); check("idle_press", d, 32'h0);
        bus_rd(A_REL, d);   check("idle_rel", d, 32'h0);
        check("idle_irq", 32'(irq), 32'd0);

        // strobe held: ack alternates 1,0,1,0
        addr = A_STATE; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);

        // pin1 bounces every 2 cycles: never long enough to be accepted
        for (int i = 0; i < 15; i++) begin
            keys[1] = ~keys[1];
            bus_rd(A_STATE, d);
            check("bounce_state", d, 32'h0);
        end
        keys[1] = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(A_STATE, d); check("bounce_state_end", d, 32'h0);
        bus_rd(A_PRESS, d); check("bounce_press", d, 32'h0);
        bus_rd(A_REL, d);   check("bounce_rel", d, 32'h0);

        // pin0 press sampled at edge P; db changes at P+5
        keys[0] = 1'b0;
        repeat (5) @(negedge clk);
        bus_rd(A_STATE, d); check("press_not_early", d, 32'h0);
        bus_rd(A_PRESS, d); check("press_flag", d, 32'h1);
        bus_rd(A_STATE, d); check("press_state", d, 32'h1);
        bus_rd(A_REL, d);   check("press_no_rel", d, 32'h0);

        keys[0] = 1'b1;
        repeat (10) @(negedge clk);
        bus_rd(A_REL, d); check("rel_flag", d, 32'h1);
        bus_wr(A_PRESS, 32'h1, irq_w);
        bus_wr(A_REL, 32'h1, irq_w);
        bus_rd(A_PRESS, d); check("w1c_press", d, 32'h0);
        bus_rd(A_REL, d);   check("w1c_rel", d, 32'h0);
        bus_wr(A_STATE, 32'hF, irq_w);
        bus_rd(A_STATE, d); check("state_ro", d, 32'h0);

        // interrupt path
        bus_wr(A_IE, 32'h1, irq_w);
        bus_rd(A_IE, d); check("ie_rd", d, 32'h1);
        check("irq_ie_only", 32'(irq), 32'd0);
        keys[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("irq_press_early", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_press", 32'(irq), 32'd1);
        bus_wr(A_PRESS, 32'h1, irq_w);
        check("irq_after_w1c", 32'(irq_w), 32'd0);
        keys[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("irq_rel_early", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rel", 32'(irq), 32'd1);
        bus_rd(A_REL, d); check("irq_rel_flag", d, 32'h1);

        // W1C of bit2 lands on the same edge as the bit2 press pulse
        keys[2] = 1'b0;
        repeat (5) @(negedge clk);
        bus_wr(A_PRESS, 32'h4, irq_w);
        bus_rd(A_PRESS, d); check("set_beats_clr", d, 32'h4);
        bus_rd(A_STATE, d); check("bit2_state", d, 32'h4);

        // reset during a 2-cycle-old pin3 count
        check("pre_rst_irq", 32'(irq), 32'd1);
        keys[3] = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_dat", rdat, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_wr(A_IE, 32'hF, irq_w);
        repeat (3) @(negedge clk);
        check("redetect_early", 32'(irq), 32'd0);
        @(negedge clk);
        check("redetect_irq", 32'(irq), 32'd1);
        bus_rd(A_STATE, d); check("redetect_state", d, 32'hC);
        bus_rd(A_PRESS, d); check("redetect_press", d, 32'hC);
        bus_rd(A_REL, d);   check("redetect_rel", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_wb.md
# key_debounce_wb

Wishbone-slave input port for push-buttons/keys: the input counterpart of the LED output port on the same SoC bus. Each of PORT_WIDTH raw pins is synchronized, debounced by a per-bit stable-time counter, and exposed as a level register. Per-bit sticky press/release flags can raise a maskable interrupt toward the processor. Board-level keys (active-low on the DE-class boards) connect directly to `key_port_i`.

## Interface
- PORT_WIDTH, 1: number of key inputs (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a change (1 ms at 50 MHz); ≥2.
- ACTIVE_LOW, 1: 1 = pin low means pressed; inverted after synchronization.
- Dw, 32: Wishbone data width.
- Aw, 2: Wishbone word-address width.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- key_port_i  in  PORT_WIDTH  raw key pins, asynchronous to clk.
- sa_dat_i  in  Dw  write data.
- sa_sel_i  in  Dw/8  byte selects; ignored, full-word access.
- sa_addr_i  in  Aw  word address.
- sa_stb_i, sa_cyc_i, sa_we_i  in  1 each  Wishbone strobe/cycle/write.
- sa_dat_o  out  Dw  read data, registered.
- sa_ack_o  out  1  acknowledge.
- sa_err_o, sa_rty_o  out  1 each  tied 0.
- irq  out  1  interrupt, active-high level.

## Operation
- Sync: 2-FF synchronizer per bit, reset to the inactive pin level (1 if ACTIVE_LOW, else 0), so no spurious press after reset. Polarity applied after the 2nd FF: `s` = 1 means pressed.
- Debounce, per bit: state `db` (reset 0) and counter `cnt` of width clog2(DEBOUNCE_CYCLES) (reset 0).
  - s == db: cnt <= 0.
  - s != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0, pulse press (0→1) or release (1→0).
  - Any bounce back to db before the count completes restarts the count from 0.
- Registers, word addressed; bits above PORT_WIDTH read 0:
  - 0 STATE: RO, db[PORT_WIDTH-1:0]. Writes ignored.
  - 1 PRESS: sticky flags, set by press pulse, write-1-to-clear.
  - 2 RELEASE: sticky flags, set by release pulse, W1C.
  - 3 IE: RW interrupt enable mask, reset 0.
- If a hardware set and a W1C clear hit the same bit in the same cycle, the set wins and the flag stays 1.
- irq = |((PRESS | RELEASE) & IE), driven from registers with no extra logic stage.
- Reset mid-debounce: all counters, flags and db clear immediately. A key still held when reset deasserts is re-detected as a press after the debounce time.

## Timing
- Bus: on cycle N with stb&cyc&!ack, ack is 1 at N+1 for exactly one cycle and then drops. sa_dat_o is valid with ack and is 0 when ack is 0. A write takes effect at the same edge that raises ack.
- Back-to-back accesses with stb held high: ack toggles 1,0,1,…, one transfer per 2 cycles.
- Latency: a clean pin change at edge P reaches `s` at P+2. db updates at P+2+DEBOUNCE_CYCLES-1 together with the flag set. irq is visible the same cycle as the flag.
- Reset values: sa_dat_o=0, sa_ack_o=0, irq=0, sa_err_o=sa_rty_o=0.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, PORT_WIDTH=4, ACTIVE_LOW=1.
- Reset release with pins = 4'hF, idle 20 cycles -> STATE=0, PRESS=0, RELEASE=0, irq=0.
- Pin0 driven low at edge P and held -> STATE bit0=1 and PRESS=0x1 exactly at P+5; read of PRESS returns 0x00000001 with ack 1 cycle after stb.
- Pin1 toggles low/high every 2 cycles for 30 cycles, then settles high -> STATE, PRESS and RELEASE stay 0 throughout.
- IE=0x1 written, pin0 pressed -> irq=1 when the flag sets. Write 0x1 to PRESS -> irq=0 the next cycle. Pin0 released -> RELEASE=0x1, irq=1.
- W1C of PRESS bit2 issued in the same cycle the bit2 press pulse fires -> PRESS bit2 reads 1.
- reset_n asserted during a 2-cycle-old pin3 press count, deasserted with pin3 still low -> outputs 0 immediately. STATE bit3=1 appears 5 cycles after the sync FFs see the low pin.
